// File: rtl/upload_pkg.sv
// Shared constants and frame state encoding for the upload packer.
package upload_pkg;

    localparam logic [7:0] UPLOAD_HDR0            = 8'hAA;
    localparam logic [7:0] UPLOAD_HDR1            = 8'h44;
    localparam logic [7:0] UPLOAD_SOURCE_UART     = 8'h01;
    localparam int         UPLOAD_FRAME_OVERHEAD  = 6;

    typedef enum logic [2:0] {
        S_COLLECT = 3'd0,
        S_HDR0    = 3'd1,
        S_HDR1    = 3'd2,
        S_SRC     = 3'd3,
        S_LENH    = 3'd4,
        S_LENL    = 3'd5,
        S_PAY     = 3'd6,
        S_CSUM    = 3'd7
    } frame_state_t;

endpackage

// File: rtl/upload_packer_if.sv
// Upload byte stream in, framed byte stream out.
// slave = packer side, master = source/sink side.
interface upload_packer_if;
    logic       upload_active;
    logic       upload_req;
    logic [7:0] upload_data;
    logic [7:0] upload_source;
    logic       upload_valid;
    logic       upload_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       frame_busy;

    modport slave (
        input  upload_active, upload_req, upload_data, upload_source, upload_valid,
        output upload_ready,
        output out_data, out_valid, frame_busy,
        input  out_ready
    );

    modport master (
        output upload_active, upload_req, upload_data, upload_source, upload_valid,
        input  upload_ready,
        input  out_data, out_valid, frame_busy,
        output out_ready
    );
endinterface

// File: rtl/upload_payload_ram.sv
// Simple dual-port payload buffer: one write port, one synchronous read port.
module upload_payload_ram #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);
    logic [7:0] mem [0:(1<<AW)-1];

    // write on strobe, read registered every cycle
    always_ff @(posedge clk) begin
        if (we)
            mem[waddr] <= wdata;
        rdata <= mem[raddr];
    end
endmodule

// File: rtl/upload_packer.sv
// Buffers one upload burst and emits it as AA 44 src lenH lenL payload csum.
// Optional idle-timeout close: define UPLOAD_PACKER_TIMEOUT_EN.
module upload_packer
    import upload_pkg::*;
#(
    parameter int         MAX_PAYLOAD    = 64,
    parameter int         TIMEOUT_CYCLES = 60000,
    parameter logic [7:0] HDR0           = UPLOAD_HDR0,
    parameter logic [7:0] HDR1           = UPLOAD_HDR1
) (
    input logic             clk,
    input logic             rst,
    upload_packer_if.slave  up
);
    localparam int            CW      = $clog2(MAX_PAYLOAD + 1);
    localparam int            AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PAYLOAD);

    frame_state_t  state;
    logic [CW-1:0] count;
    logic [CW-1:0] rd_idx;
    logic [7:0]    csum;
    logic [7:0]    src_lat;
    logic [15:0]   len_lat;
    logic          active_q;
    logic [7:0]    out_data_q;
    logic          out_valid_q;
    logic          frame_busy_q;

    logic          src_mismatch;
    logic          ready;
    logic          accept;
    logic [CW-1:0] count_nx;
    logic          active_fall;
    logic          timeout_hit;
    logic          close;
    logic          out_fire;
    logic          take;
    logic [CW-1:0] raddr_full;
    logic [AW-1:0] ram_raddr;
    logic [7:0]    ram_rdata;
    logic [7:0]    csum_final;
    logic          unused_req;

    assign unused_req = up.upload_req;

    // A byte from a different source ends the current burst instead of joining it
    assign src_mismatch = (count != '0) && (up.upload_source != src_lat);
    assign ready        = !rst && (state == S_COLLECT) && (count < MAX_CNT) && !src_mismatch;
    assign accept       = up.upload_valid && ready;
    assign count_nx     = count + CW'(accept);
    assign active_fall  = active_q && !up.upload_active;

    // count_nx folds in a byte accepted in the same cycle, so a fall that
    // coincides with the last byte (or with reaching full) closes exactly once
    assign close = (state == S_COLLECT) &&
                   ((active_fall && (count_nx != '0)) ||
                    (count_nx == MAX_CNT) ||
                    (up.upload_valid && src_mismatch) ||
                    timeout_hit);

    assign out_fire = out_valid_q && up.out_ready;

    // Payload prefetch: the RAM address runs one ahead whenever a payload
    // byte is moved into out_data, so ram_rdata always holds buf[rd_idx]
    assign take       = out_fire && ((state == S_LENL) ||
                                     ((state == S_PAY) && (rd_idx != len_lat[CW-1:0])));
    assign raddr_full = rd_idx + CW'(take);
    assign ram_raddr  = raddr_full[AW-1:0];

    assign csum_final = src_lat + len_lat[15:8] + len_lat[7:0] + csum;

    assign up.upload_ready = ready;
    assign up.out_data     = out_data_q;
    assign up.out_valid    = out_valid_q;
    assign up.frame_busy   = frame_busy_q;

    upload_payload_ram #(.AW(AW)) u_ram (
        .clk   (clk),
        .we    (accept),
        .waddr (count[AW-1:0]),
        .wdata (up.upload_data),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

`ifdef UPLOAD_PACKER_TIMEOUT_EN
    localparam int            TW           = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] idle_cnt;

    assign timeout_hit = (state == S_COLLECT) && (count != '0) && !accept &&
                         (idle_cnt == TIMEOUT_LAST);

    // idle cycles since the last accepted byte of a non-empty burst
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            idle_cnt <= '0;
        else if ((state != S_COLLECT) || (count == '0) || accept || timeout_hit)
            idle_cnt <= '0;
        else
            idle_cnt <= idle_cnt + TW'(1);
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;

    assign timeout_hit = 1'b0;
`endif

    // collect/emit state machine with registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_COLLECT;
            count        <= '0;
            rd_idx       <= '0;
            csum         <= '0;
            src_lat      <= '0;
            len_lat      <= '0;
            active_q     <= 1'b0;
            out_data_q   <= '0;
            out_valid_q  <= 1'b0;
            frame_busy_q <= 1'b0;
        end else begin
            active_q <= up.upload_active;
            case (state)
                S_COLLECT: begin
                    if (accept) begin
                        count <= count_nx;
                        csum  <= csum + up.upload_data;
                        if (count == '0)
                            src_lat <= up.upload_source;
                    end
                    if (close) begin
                        len_lat      <= 16'(count_nx);
                        state        <= S_HDR0;
                        out_data_q   <= HDR0;
                        out_valid_q  <= 1'b1;
                        frame_busy_q <= 1'b1;
                    end
                end
                S_HDR0: if (out_fire) begin
                    state      <= S_HDR1;
                    out_data_q <= HDR1;
                end
                S_HDR1: if (out_fire) begin
                    state      <= S_SRC;
                    out_data_q <= src_lat;
                end
                S_SRC: if (out_fire) begin
                    state      <= S_LENH;
                    out_data_q <= len_lat[15:8];
                end
                S_LENH: if (out_fire) begin
                    state      <= S_LENL;
                    out_data_q <= len_lat[7:0];
                end
                S_LENL: if (out_fire) begin
                    state      <= S_PAY;
                    out_data_q <= ram_rdata;
                    rd_idx     <= rd_idx + CW'(1);
                end
                S_PAY: if (out_fire) begin
                    if (rd_idx == len_lat[CW-1:0]) begin
                        state      <= S_CSUM;
                        out_data_q <= csum_final;
                    end else begin
                        out_data_q <= ram_rdata;
                        rd_idx     <= rd_idx + CW'(1);
                    end
                end
                S_CSUM: if (out_fire) begin
                    state        <= S_COLLECT;
                    out_data_q   <= '0;
                    out_valid_q  <= 1'b0;
                    frame_busy_q <= 1'b0;
                    count        <= '0;
                    csum         <= '0;
                    rd_idx       <= '0;
                end
                default: state <= S_COLLECT;
            endcase
        end
    end
endmodule

// File: tb/tb_upload_packer.sv
// Directed bench for upload_packer with a byte-level scoreboard on the output stream.
module tb_upload_packer;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   stall_cnt = 0;
    bit   ready_mode = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] pl[$];
    bit         stall_pend = 1'b0;
    logic [7:0] stall_data = '0;

    upload_packer_if bus();

    upload_packer dut (
        .clk (clk),
        .rst (rst),
        .up  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Sink: ready held high, or toggled every cycle
    always @(posedge clk) begin
        #1;
        bus.out_ready = ready_mode ? ~bus.out_ready : 1'b1;
    end

    // Output monitor: pop and compare each accepted byte, check stall stability
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.frame_busy)
                chk("ready_low_while_busy", {31'd0, bus.upload_ready}, 32'd0);
            if (stall_pend && bus.out_valid)
                chk("stall_stable", {24'd0, bus.out_data}, {24'd0, stall_data});
            if (bus.out_valid && !bus.out_ready)
                stall_cnt++;
            if (bus.out_valid && bus.out_ready) begin
                chk("sb_nonempty", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0)
                    chk("out_byte", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
            end
            stall_pend = bus.out_valid && !bus.out_ready;
            stall_data = bus.out_data;
        end else begin
            stall_pend = 1'b0;
        end
    end

    // Expected frame from the current payload list
    task automatic push_frame(input logic [7:0] src);
        logic [7:0] sum;
        logic [7:0] len;
        len = 8'(pl.size());
        sum = src + len;
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'h44);
        exp_q.push_back(src);
        exp_q.push_back(8'h00);
        exp_q.push_back(len);
        foreach (pl[i]) begin
            exp_q.push_back(pl[i]);
            sum = sum + pl[i];
        end
        exp_q.push_back(sum);
        pl.delete();
    endtask

    // Present one byte and hold it until accepted; returns at posedge+1
    task automatic send_byte(input logic [7:0] d, input logic [7:0] s);
        int n = 0;
        bus.upload_valid  = 1'b1;
        bus.upload_data   = d;
        bus.upload_source = s;
        @(negedge clk);
        while (!bus.upload_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("send_tmo", {31'd0, n < 500}, 32'd1);
        @(posedge clk);
        #1;
        bus.upload_valid = 1'b0;
    endtask

    // Wait for a frame to start and finish; ncyc = cycles with frame_busy high
    task automatic wait_frame(output int ncyc);
        int n = 0;
        ncyc = 0;
        @(negedge clk);
        while (!bus.frame_busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("frame_start_tmo", {31'd0, n < 200}, 32'd1);
        while (bus.frame_busy && ncyc < 500) begin
            ncyc++;
            @(negedge clk);
        end
        chk("frame_end_tmo", {31'd0, ncyc < 500}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nc;
        int seen;
        rst = 1'b1;
        bus.upload_active = 1'b0;
        bus.upload_req    = 1'b0;
        bus.upload_data   = '0;
        bus.upload_source = '0;
        bus.upload_valid  = 1'b0;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_upload_ready", {31'd0, bus.upload_ready}, 32'd0);
        chk("rst_out_valid",    {31'd0, bus.out_valid},    32'd0);
        chk("rst_out_data",     {24'd0, bus.out_data},     32'd0);
        chk("rst_frame_busy",   {31'd0, bus.frame_busy},   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", {31'd0, bus.upload_ready}, 32'd1);
        @(posedge clk);
        #1;

        // 3-byte burst closed by active falling
        bus.upload_active = 1'b1;
        bus.upload_req    = 1'b1;
        pl = '{8'h11, 8'h22, 8'h33};
        push_frame(8'h01);
        send_byte(8'h11, 8'h01);
        send_byte(8'h22, 8'h01);
        send_byte(8'h33, 8'h01);
        bus.upload_active = 1'b0;
        bus.upload_req    = 1'b0;
        wait_frame(nc);
        chk("f3_cycles", nc, 32'd9);
        chk("f3_drained", exp_q.size(), 32'd0);

        // 64 bytes with active held high: closes on full
        bus.upload_active = 1'b1;
        for (int i = 0; i < 64; i++) pl.push_back(8'h01);
        push_frame(8'h01);
        for (int i = 0; i < 64; i++) send_byte(8'h01, 8'h01);
        chk("full_ready_low", {31'd0, bus.upload_ready}, 32'd0);
        chk("full_busy",      {31'd0, bus.frame_busy},   32'd1);
        wait_frame(nc);
        chk("f64_cycles", nc, 32'd70);
        chk("f64_drained", exp_q.size(), 32'd0);
        bus.upload_active = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        // source change closes the frame; the new-source byte forms its own frame
        bus.upload_active = 1'b1;
        pl = '{8'h0A, 8'h0B};
        push_frame(8'h01);
        send_byte(8'h0A, 8'h01);
        send_byte(8'h0B, 8'h01);
        send_byte(8'h5C, 8'h02);
        chk("mismatch_f1_drained", exp_q.size(), 32'd0);
        pl = '{8'h5C};
        push_frame(8'h02);
        bus.upload_active = 1'b0;
        wait_frame(nc);
        chk("f02_cycles", nc, 32'd7);
        chk("f02_drained", exp_q.size(), 32'd0);

        // sink toggling ready: stable data and intact order
        ready_mode = 1'b1;
        stall_cnt  = 0;
        bus.upload_active = 1'b1;
        for (int i = 0; i < 5; i++) pl.push_back(8'(8'h10 + i));
        push_frame(8'h01);
        for (int i = 0; i < 5; i++) send_byte(8'(8'h10 + i), 8'h01);
        bus.upload_active = 1'b0;
        wait_frame(nc);
        chk("stall_drained", exp_q.size(), 32'd0);
        chk("stall_seen", {31'd0, stall_cnt > 0}, 32'd1);
        ready_mode = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // active pulse with no data: no frame
        bus.upload_active = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        bus.upload_active = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        chk("empty_no_frame", seen, 32'd0);
        @(posedge clk);
        #1;

        // reset during payload emission
        bus.upload_active = 1'b1;
        pl = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        push_frame(8'h01);
        for (int i = 0; i < 4; i++) send_byte(8'(8'hC1 + i), 8'h01);
        bus.upload_active = 1'b0;
        seen = 0;
        while (exp_q.size() > 4 && seen < 200) begin
            @(negedge clk);
            seen++;
        end
        chk("pay_reach_tmo", {31'd0, seen < 200}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid",  {31'd0, bus.out_valid},  32'd0);
        chk("midrst_frame_busy", {31'd0, bus.frame_busy}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.upload_active = 1'b1;
        pl = '{8'h5A};
        push_frame(8'h01);
        send_byte(8'h5A, 8'h01);
        bus.upload_active = 1'b0;
        wait_frame(nc);
        chk("post_rst_cycles", nc, 32'd7);
        chk("post_rst_drained", exp_q.size(), 32'd0);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
